// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: header tag, FSM states
// and the helper that builds a source-tagged header byte.
package uart_tx_arbiter_pkg;

    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after last_grant+1.
// Ports: req, last_grant in; one-hot gnt and binary gnt_id out.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester
    // after last_grant is the one that sticks.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8-bit UART tx channel between packet sources.
// Ports: clk, rst_n, req/req_data in; req_ack, req_done, busy out;
//        tx_data/tx_vld out, tx_rdy in (byte moves on tx_vld & tx_rdy).
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PKT_BYTES = 4,
    parameter int HEADER_EN = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*PKT_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           busy,
    output logic [7:0]                     tx_data,
    output logic                           tx_vld,
    input  logic                           tx_rdy
);

    import uart_tx_arbiter_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = PKT_BYTES * 8;
    localparam int NB = PKT_BYTES + HEADER_EN;
    localparam int CW = $clog2(NB + 1);

    state_e               state_q, state_d;
    logic [PW-1:0]        pkt_q, pkt_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 vld_q, vld_d;
    logic [7:0]           data_q, data_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_id;
    logic [PW-1:0]        gnt_pkt;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req        (req),
        .last_grant (last_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign gnt_pkt = req_data[int'(gnt_id)*PW +: PW];

    // Byte idx of the outgoing stream: optional header, then payload
    // little-endian.
    function automatic logic [7:0] byte_sel(
        input logic [PW-1:0] pkt,
        input logic [CW-1:0] idx,
        input logic [IW-1:0] id
    );
        int k;
        if (HEADER_EN != 0 && idx == '0) begin
            return hdr_byte(4'(id));
        end
        k = int'(idx) - HEADER_EN;
        return pkt[8*k +: 8];
    endfunction

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        vld_d   = vld_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    pkt_d   = gnt_pkt;
                    last_d  = gnt_id;
                    cnt_d   = '0;
                    ack_d   = gnt;
                    vld_d   = 1'b1;
                    data_d  = byte_sel(gnt_pkt, '0, gnt_id);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (vld_q && tx_rdy) begin
                    if (cnt_q == CW'(NB - 1)) begin
                        vld_d   = 1'b0;
                        done_d  = NUM_REQ'(1) << last_q;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = byte_sel(pkt_q, cnt_q + CW'(1), last_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    assign req_ack  = ack_q;
    assign req_done = done_q;
    assign busy     = busy_q;
    assign tx_vld   = vld_q;
    assign tx_data  = data_q;

endmodule
